// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the branch target predictor:
// 2-bit direction counter encoding and the predictor mode selector.
`timescale 1ns/1ps
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strongly not taken
    localparam ctr_t WNT = 2'b01;  // weakly not taken (reset value)
    localparam ctr_t WT  = 2'b10;  // weakly taken (value on allocation)
    localparam ctr_t ST  = 2'b11;  // strongly taken

    typedef enum logic [1:0] {
        BP_STATIC  = 2'd0,
        BP_BIMODAL = 2'd1,
        BP_GSHARE  = 2'd2
    } bp_mode_e;

endpackage

// File: rtl/branch_target_predictor_sat_ctr2.sv
// Combinational next-state for a 2-bit saturating direction counter.
// Taken outcomes count up to ST, not-taken outcomes count down to SNT.
`timescale 1ns/1ps
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next
);

    // Step toward the observed outcome, holding at either end.
    always_comb begin
        next = ctr;
        if (taken) begin
            if (ctr != ST) begin
                next = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a selectable direction
// predictor (static / bimodal / gshare). Fetch looks up combinationally;
// the resolved branch from MEM trains the tables on the clock edge and
// feeds a saturating mispredict counter. A lookup that coincides with an
// update to the same entry sees the old contents (no bypass).
`timescale 1ns/1ps
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned TAG_W   = 8,
    parameter bp_mode_e    MODE    = BP_BIMODAL,
    parameter int unsigned HIST_W  = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    // Storage: flop arrays so the whole table clears in one reset cycle.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       pht_q    [ENTRIES];

    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [HIST_W:0]   ghr_shift;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] if_idx, if_pht_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] u_idx, u_pht_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             mismatch;
    logic             btb_we, pht_we;
    logic [1:0]       ctr_next;
    logic [1:0]       pht_wdata;

    // History folds into the PHT index only in gshare mode.
    assign ghr_ext = IDX_W'(ghr_q);

    // ---------------- Lookup (fetch side) ----------------
    assign if_idx     = if_pc[IDX_W-1:0];
    assign if_tag     = if_pc[IDX_W +: TAG_W];
    assign if_pht_idx = (MODE == BP_GSHARE) ? (if_idx ^ ghr_ext) : if_idx;

    // Combinational read of the current table contents.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = 1'b0;
        pred_target = '0;
        if (pred_hit) begin
            pred_taken  = (MODE == BP_STATIC) ? 1'b1 : pht_q[if_pht_idx][1];
            pred_target = target_q[if_idx];
        end
    end

    // ---------------- Update (MEM side) ----------------
    assign u_idx     = upd_pc[IDX_W-1:0];
    assign u_tag     = upd_pc[IDX_W +: TAG_W];
    assign u_pht_idx = (MODE == BP_GSHARE) ? (u_idx ^ ghr_ext) : u_idx;
    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign mismatch   = (upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target));
    assign mispredict = upd_valid && mismatch;

    sat_ctr2 u_sat_ctr2 (
        .ctr   (pht_q[u_pht_idx]),
        .taken (upd_taken),
        .next  (ctr_next)
    );

    // Taken branches always (re)write the BTB entry: on a hit this refreshes
    // the target, on a miss it allocates over whatever was there.
    assign btb_we    = upd_valid && upd_taken;
    // Counters train on hits; a fresh allocation starts at weakly taken.
    assign pht_we    = upd_valid && (u_hit || upd_taken);
    assign pht_wdata = u_hit ? ctr_next : WT;

    // Next-state for history and mispredict counter.
    always_comb begin
        ghr_shift = {ghr_q, upd_taken};
        ghr_d     = ghr_q;
        cnt_d     = cnt_q;
        if (MODE != BP_GSHARE) begin
            ghr_d = '0;
        end else if (upd_valid) begin
            ghr_d = ghr_shift[HIST_W-1:0];
        end
        if (mispredict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // BTB entries: clear on reset, write on a taken resolved branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (btb_we) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

    // Pattern history table: reset to weakly not taken, train on update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                pht_q[i] <= WNT;
            end
        end else if (pht_we) begin
            pht_q[u_pht_idx] <= pht_wdata;
        end
    end

    // Global history and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;

    // Upper PC bits and the shifted-out history bit are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{if_pc, upd_pc, ghr_shift[HIST_W]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: a bimodal instance driven through
// directed scenarios, and a gshare instance with a 2-bit mispredict
// counter trained on a repeating T,T,N pattern against a reference model.
`timescale 1ns/1ps
module tb_branch_target_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Bimodal instance (A)
    logic [31:0] a_if_pc, a_target, a_upd_pc, a_upd_target, a_upd_pred_target;
    logic        a_hit, a_taken, a_upd_valid, a_upd_taken, a_upd_pred_taken, a_misp;
    logic [15:0] a_cnt;

    // Gshare instance (B)
    logic [31:0] b_if_pc, b_target, b_upd_pc, b_upd_target, b_upd_pred_target;
    logic        b_hit, b_taken, b_upd_valid, b_upd_taken, b_upd_pred_taken, b_misp;
    logic [1:0]  b_cnt;

    branch_target_predictor #(
        .XLEN(32), .ENTRIES(32), .TAG_W(8), .MODE(BP_BIMODAL), .HIST_W(5), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .if_pc(a_if_pc),
        .pred_hit(a_hit), .pred_taken(a_taken), .pred_target(a_target),
        .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_taken(a_upd_taken),
        .upd_target(a_upd_target), .upd_pred_taken(a_upd_pred_taken),
        .upd_pred_target(a_upd_pred_target),
        .mispredict(a_misp), .mispredict_cnt(a_cnt)
    );

    branch_target_predictor #(
        .XLEN(32), .ENTRIES(32), .TAG_W(8), .MODE(BP_GSHARE), .HIST_W(5), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .if_pc(b_if_pc),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_target),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
        .upd_target(b_upd_target), .upd_pred_taken(b_upd_pred_taken),
        .upd_pred_target(b_upd_pred_target),
        .mispredict(b_misp), .mispredict_cnt(b_cnt)
    );

    // Observable selectors for scoreboard entries
    localparam int A_HIT = 0, A_TAKEN = 1, A_TGT = 2, A_MISP = 3, A_CNT = 4;
    localparam int B_HIT = 5, B_TAKEN = 6, B_TGT = 7, B_MISP = 8, B_CNT = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A_HIT:   return 32'(a_hit);
            A_TAKEN: return 32'(a_taken);
            A_TGT:   return a_target;
            A_MISP:  return 32'(a_misp);
            A_CNT:   return 32'(a_cnt);
            B_HIT:   return 32'(b_hit);
            B_TAKEN: return 32'(b_taken);
            B_TGT:   return b_target;
            B_MISP:  return 32'(b_misp);
            B_CNT:   return 32'(b_cnt);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Compare everything expected for this cycle, half a period after drive.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    end

    task automatic a_step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utgt,
                          input logic upt, input logic [31:0] uptgt);
        @(posedge clk);
        #1;
        a_if_pc = lpc; a_upd_valid = uv; a_upd_pc = upc; a_upd_taken = ut;
        a_upd_target = utgt; a_upd_pred_taken = upt; a_upd_pred_target = uptgt;
        $display("A txn: lookup=0x%0h upd_valid=%0b upd_pc=0x%0h taken=%0b target=0x%0h pred=%0b/0x%0h",
                 lpc, uv, upc, ut, utgt, upt, uptgt);
    endtask

    task automatic a_exp_lookup(input string s, input logic h, input logic t, input logic [31:0] tg);
        push({s, "_hit"}, A_HIT, 32'(h));
        push({s, "_taken"}, A_TAKEN, 32'(t));
        push({s, "_target"}, A_TGT, tg);
    endtask

    task automatic b_step(input logic [31:0] pc, input logic ut, input logic [31:0] utgt,
                          input logic upt, input logic [31:0] uptgt, input logic uv);
        @(posedge clk);
        #1;
        b_if_pc = pc; b_upd_valid = uv; b_upd_pc = pc; b_upd_taken = ut;
        b_upd_target = utgt; b_upd_pred_taken = upt; b_upd_pred_target = uptgt;
        $display("B txn: pc=0x%0h upd_valid=%0b taken=%0b pred=%0b/0x%0h", pc, uv, ut, upt, uptgt);
    endtask

    // Reference model for the gshare instance
    logic        m_valid [32];
    logic [7:0]  m_tag   [32];
    logic [31:0] m_tgt   [32];
    logic [1:0]  m_pht   [32];
    logic [4:0]  m_ghr;
    int          m_cnt;

    initial begin
        rst = 1'b0;
        a_if_pc = '0; a_upd_valid = 1'b0; a_upd_pc = '0; a_upd_taken = 1'b0;
        a_upd_target = '0; a_upd_pred_taken = 1'b0; a_upd_pred_target = '0;
        b_if_pc = '0; b_upd_valid = 1'b0; b_upd_pc = '0; b_upd_taken = 1'b0;
        b_upd_target = '0; b_upd_pred_taken = 1'b0; b_upd_pred_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("rst", 0, 0, 0);
        push("rst_misp", A_MISP, 0);
        push("rst_cnt", A_CNT, 0);
        push("rst_b_cnt", B_CNT, 0);

        // First taken resolve allocates; lookup this cycle still sees old state
        a_step(32'h10, 1, 32'h10, 1, 32'h40, 0, 0);
        push("alloc_misp", A_MISP, 1);
        push("alloc_same_cycle_hit", A_HIT, 0);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("alloc_next", 1, 1, 32'h40);
        push("alloc_cnt", A_CNT, 1);

        // Not-taken training: 10 -> 01 -> 00 -> 00
        a_step(32'h10, 1, 32'h10, 0, 0, 1, 32'h40);
        push("nt1_misp", A_MISP, 1);
        a_step(32'h10, 1, 32'h10, 0, 0, 0, 0);
        a_exp_lookup("nt1_after", 1, 0, 32'h40);
        push("nt2_misp", A_MISP, 0);
        push("nt1_cnt", A_CNT, 2);
        a_step(32'h10, 1, 32'h10, 0, 0, 0, 0);
        a_exp_lookup("nt2_after", 1, 0, 32'h40);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("nt3_floor", 1, 0, 32'h40);
        push("nt3_cnt", A_CNT, 2);

        // Taken on hit with wrong predicted target: counter 00 -> 01, target refresh
        a_step(32'h10, 1, 32'h10, 1, 32'h48, 1, 32'h40);
        push("tgt_misp", A_MISP, 1);
        a_step(32'h10, 1, 32'h10, 1, 32'h48, 1, 32'h48);
        a_exp_lookup("tgt_after", 1, 0, 32'h48);
        push("tgt_cnt", A_CNT, 3);
        push("match_misp", A_MISP, 0);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("ctr_up", 1, 1, 32'h48);
        push("match_cnt", A_CNT, 3);

        // Alias: 0x30 shares the index with 0x10 but has a different tag
        a_step(32'h30, 1, 32'h30, 1, 32'h90, 0, 0);
        push("alias_pre_hit", A_HIT, 0);
        push("alias_misp", A_MISP, 1);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        push("alias_old_hit", A_HIT, 0);
        push("alias_cnt", A_CNT, 4);
        a_step(32'h30, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("alias_new", 1, 1, 32'h90);

        // Same-cycle lookup and update on the same index
        a_step(32'h30, 1, 32'h10, 1, 32'h44, 0, 0);
        a_exp_lookup("same_cycle", 1, 1, 32'h90);
        a_step(32'h30, 0, 0, 0, 0, 0, 0);
        push("same_next_evicted", A_HIT, 0);
        push("same_cnt", A_CNT, 5);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        a_exp_lookup("same_next", 1, 1, 32'h44);

        // upd_valid=0 leaves state alone and suppresses mispredict
        a_step(32'h70, 0, 32'h70, 1, 32'h77, 0, 0);
        push("novalid_misp", A_MISP, 0);
        a_step(32'h70, 0, 0, 0, 0, 0, 0);
        push("novalid_hit", A_HIT, 0);
        push("novalid_cnt", A_CNT, 5);

        // Not-taken miss does not allocate
        a_step(32'h60, 1, 32'h60, 0, 0, 0, 0);
        push("ntmiss_misp", A_MISP, 0);
        a_step(32'h60, 0, 0, 0, 0, 0, 0);
        push("ntmiss_hit", A_HIT, 0);

        // Reset wins over a concurrent update
        a_step(32'h50, 1, 32'h50, 1, 32'h55, 0, 0);
        rst = 1'b0;
        a_step(32'h50, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        a_exp_lookup("rst_upd", 0, 0, 0);
        push("rst_upd_cnt", A_CNT, 0);
        a_step(32'h10, 0, 0, 0, 0, 0, 0);
        push("rst_upd_old", A_HIT, 0);

        // Gshare: T,T,N at pc=0x08 for 20 iterations against the model
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_pht[i] = 2'b01;
        end
        m_ghr = '0;
        m_cnt = 0;
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] pc, tgt, ptgt;
                logic [4:0]  idx, pidx;
                logic [7:0]  tg;
                logic        t, hit, ptk, mis;
                pc   = 32'h08;
                tgt  = 32'h20;
                t    = (k != 2);
                idx  = pc[4:0];
                tg   = pc[12:5];
                pidx = idx ^ m_ghr;
                hit  = m_valid[idx] && (m_tag[idx] == tg);
                ptk  = hit && m_pht[pidx][1];
                ptgt = hit ? m_tgt[idx] : 32'h0;
                mis  = (t != ptk) || (t && (tgt != ptgt));
                b_step(pc, t, tgt, ptk, ptgt, 1'b1);
                push($sformatf("g%0d_%0d_hit", it, k), B_HIT, 32'(hit));
                push($sformatf("g%0d_%0d_taken", it, k), B_TAKEN, 32'(ptk));
                push($sformatf("g%0d_%0d_target", it, k), B_TGT, ptgt);
                push($sformatf("g%0d_%0d_misp", it, k), B_MISP, 32'(mis));
                push($sformatf("g%0d_%0d_cnt", it, k), B_CNT, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
                if (t) begin
                    m_pht[pidx] = hit ? ((m_pht[pidx] == 2'b11) ? 2'b11 : m_pht[pidx] + 2'd1) : 2'b10;
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                    m_tgt[idx]   = tgt;
                end else if (hit) begin
                    m_pht[pidx] = (m_pht[pidx] == 2'b00) ? 2'b00 : m_pht[pidx] - 2'd1;
                end
                m_ghr = {m_ghr[3:0], t};
                if (mis) m_cnt++;
            end
        end
        b_step(32'h08, 0, 0, 0, 0, 1'b0);
        push("g_final_cnt", B_CNT, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
